// File: rtl/fetch_stage_pkg.sv
// Shared widths and FSM encoding for the SIMPLE-pipeline instruction fetch stage.
package fetch_stage_pkg;
  localparam int ADDR_W = 16;
  localparam int INST_W = 16;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_e;
endpackage

// File: rtl/fetch_queue.sv
// Small power-of-two FIFO holding fetched {inst, pc1} words; clear wins over push/pop,
// and push+pop in the same cycle is legal even when full.
module fetch_queue #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        push_data,
  output logic [DATA_W-1:0]        head_data,
  output logic                     head_valid,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic              do_push, do_pop;

  always_comb begin
    do_pop   = pop && (count_q != '0) && !clear;
    do_push  = push && !clear;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      count_d = count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload needs no reset; validity lives entirely in count_q.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  // The upstream credit rule must never let a push land on a full queue without a pop.
  always_ff @(posedge clk) begin
    if (!rst) assert (!(do_push && !do_pop && (count_q == (PTR_W+1)'(DEPTH))));
  end

  assign head_data  = mem_q[rd_ptr_q];
  assign head_valid = (count_q != '0);
  assign count      = count_q;
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the fetch PC, issues reads to a 1-cycle sync RAM and
// presents queued words to decode, with stall hold, redirect flush and HLT stop.
module fetch_stage #(
  parameter int                   ADDR_W   = fetch_stage_pkg::ADDR_W,
  parameter int                   INST_W   = fetch_stage_pkg::INST_W,
  parameter int                   DEPTH    = 2,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce,
  input  logic              halt,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INST_W-1:0] imem_rdata,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc1,
  output logic              inst_valid,
  output logic [ADDR_W-1:0] fetch_pc
);
  import fetch_stage_pkg::*;

  localparam int CNT_W = $clog2(DEPTH) + 1;

  state_e                    state_q, state_d;
  logic [ADDR_W-1:0]         fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0]         req_pc_q, req_pc_d;
  logic                      req_q, req_d;
  logic                      pop, push, issue;
  logic                      head_valid;
  logic [CNT_W-1:0]          count;
  logic [INST_W+ADDR_W-1:0]  head_data, push_data;

  assign pop       = head_valid & ~stall;
  assign push      = req_q & ~redirect;
  assign push_data = {imem_rdata, req_pc_q + ADDR_W'(1)};

  always_comb begin
    // Credit check: occupancy after this edge plus the new request must fit.
    issue = (state_q == ST_RUN) && ce && !redirect &&
            (({1'b0, count} + (CNT_W+1)'(req_q)) < ((CNT_W+1)'(DEPTH) + (CNT_W+1)'(pop)));
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    req_d      = issue;
    if (issue) begin
      req_pc_d   = fetch_pc_q;
      fetch_pc_d = fetch_pc_q + ADDR_W'(1);
    end
    if (redirect) fetch_pc_d = redirect_pc;
    if (halt)     state_d    = ST_HALTED;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_RUN;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
      req_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      req_q      <= req_d;
    end
  end

  fetch_queue #(
    .DATA_W (INST_W + ADDR_W),
    .DEPTH  (DEPTH)
  ) u_queue (
    .clk        (clk),
    .rst        (reset),
    .clear      (redirect),
    .push       (push),
    .pop        (pop),
    .push_data  (push_data),
    .head_data  (head_data),
    .head_valid (head_valid),
    .count      (count)
  );

  assign imem_addr  = fetch_pc_q;
  assign fetch_pc   = fetch_pc_q;
  assign inst_valid = head_valid;
  assign inst       = head_valid ? head_data[INST_W+ADDR_W-1:ADDR_W] : '0;
  assign inst_pc1   = head_valid ? head_data[ADDR_W-1:0] : '0;
endmodule

// File: tb/tb_fetch_stage.sv
// Drives two fetch stages (RESET_PC 0 and FFFF) with directed and random traffic and
// compares every cycle against a queue-based reference model.
module tb_fetch_stage;
  localparam int AW = 16;
  localparam int IW = 16;
  localparam int DEPTH = 2;
  localparam logic [15:0] RPC0 = 16'h0000;
  localparam logic [15:0] RPC1 = 16'hFFFF;

  typedef struct {
    logic [15:0] inst;
    logic [15:0] pc1;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ce = 1'b0, halt = 1'b0, stall = 1'b0, redirect = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic [15:0] imem_addr [2];
  logic [15:0] imem_rdata [2];
  logic [15:0] inst_o [2];
  logic [15:0] pc1_o [2];
  logic [15:0] fpc_o [2];
  logic        valid_o [2];
  logic [15:0] mem [65536];

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model state: delivered-word queue, one outstanding read, fetch PC, halted flag.
  ent_t        mq [2][$];
  logic [15:0] m_fpc [2];
  logic [15:0] m_rpc [2];
  bit          m_req [2];
  bit          m_halt [2];

  always #5 clk = ~clk;

  fetch_stage #(.ADDR_W(AW), .INST_W(IW), .DEPTH(DEPTH), .RESET_PC(RPC0)) dut0 (
    .clk(clk), .reset(reset), .ce(ce), .halt(halt), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc), .imem_addr(imem_addr[0]),
    .imem_rdata(imem_rdata[0]), .inst(inst_o[0]), .inst_pc1(pc1_o[0]),
    .inst_valid(valid_o[0]), .fetch_pc(fpc_o[0]));

  fetch_stage #(.ADDR_W(AW), .INST_W(IW), .DEPTH(DEPTH), .RESET_PC(RPC1)) dut1 (
    .clk(clk), .reset(reset), .ce(ce), .halt(halt), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc), .imem_addr(imem_addr[1]),
    .imem_rdata(imem_rdata[1]), .inst(inst_o[1]), .inst_pc1(pc1_o[1]),
    .inst_valid(valid_o[1]), .fetch_pc(fpc_o[1]));

  always_ff @(posedge clk) begin
    imem_rdata[0] <= mem[imem_addr[0]];
    imem_rdata[1] <= mem[imem_addr[1]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mq[k].delete();
      m_fpc[k]  = (k == 0) ? RPC0 : RPC1;
      m_rpc[k]  = '0;
      m_req[k]  = 1'b0;
      m_halt[k] = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      bit   pop;
      bit   iss;
      int   occ;
      ent_t e;
      pop = (mq[k].size() > 0) && !stall;
      occ = mq[k].size() + int'(m_req[k]) - int'(pop);
      iss = !m_halt[k] && ce && !redirect && (occ < DEPTH);
      if (redirect) begin
        mq[k].delete();
        m_req[k] = 1'b0;
        m_fpc[k] = redirect_pc;
      end else begin
        if (pop) void'(mq[k].pop_front());
        if (m_req[k]) begin
          e.inst = mem[m_rpc[k]];
          e.pc1  = m_rpc[k] + 16'd1;
          mq[k].push_back(e);
        end
        if (iss) begin
          m_rpc[k] = m_fpc[k];
          m_fpc[k] = m_fpc[k] + 16'd1;
        end
        m_req[k] = iss;
      end
      if (halt) m_halt[k] = 1'b1;
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      bit v;
      v = (mq[k].size() > 0);
      chk($sformatf("dut%0d_valid", k), 32'(valid_o[k]), 32'(v));
      chk($sformatf("dut%0d_inst", k), 32'(inst_o[k]), v ? 32'(mq[k][0].inst) : 32'd0);
      chk($sformatf("dut%0d_pc1", k), 32'(pc1_o[k]), v ? 32'(mq[k][0].pc1) : 32'd0);
      chk($sformatf("dut%0d_fetch_pc", k), 32'(fpc_o[k]), 32'(m_fpc[k]));
      chk($sformatf("dut%0d_imem_addr", k), 32'(imem_addr[k]), 32'(m_fpc[k]));
    end
  endtask

  // One clock: drive inputs, check at the falling edge, advance the model, cross the rising edge.
  task automatic step(input logic s, input logic r, input logic [15:0] rpc,
                      input logic h, input logic c);
    stall = s; redirect = r; redirect_pc = rpc; halt = h; ce = c;
    @(negedge clk);
    check_all();
    $display("t=%0t ce=%b st=%b rd=%b h=%b | v0=%b i0=%h p0=%h f0=%h | v1=%b i1=%h p1=%h f1=%h",
             $time, ce, stall, redirect, halt, valid_o[0], inst_o[0], pc1_o[0], fpc_o[0],
             valid_o[1], inst_o[1], pc1_o[1], fpc_o[1]);
    model_step();
    @(posedge clk);
    #1;
  endtask

  // Reset pulse that starts and ends between two clock edges.
  task automatic reset_pulse();
    reset = 1'b1;
    #2;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_dut%0d_valid", k), 32'(valid_o[k]), 32'd0);
      chk($sformatf("rst_dut%0d_fetch_pc", k), 32'(fpc_o[k]), (k == 0) ? 32'(RPC0) : 32'(RPC1));
    end
    #1 reset = 1'b0;
  endtask

  initial begin
    bit          found;
    logic [15:0] frozen_pc;
    for (int i = 0; i < 65536; i++) mem[i] = 16'h1000 + 16'(i);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("por_valid", 32'(valid_o[0]), 32'd0);
    chk("por_fetch_pc", 32'(fpc_o[1]), 32'(RPC1));
    reset = 1'b0;

    // Straight-line run with first-word latency and wrap on the FFFF instance.
    step(0, 0, 16'h0, 0, 1);
    chk("lat_not_yet", 32'(valid_o[0]), 32'd0);
    step(0, 0, 16'h0, 0, 1);
    chk("lat_valid", 32'(valid_o[0]), 32'd1);
    chk("run_inst0", 32'(inst_o[0]), 32'h1000);
    chk("run_pc1_0", 32'(pc1_o[0]), 32'h0001);
    chk("wrap_inst", 32'(inst_o[1]), 32'h0FFF);
    chk("wrap_pc1", 32'(pc1_o[1]), 32'h0000);
    step(0, 0, 16'h0, 0, 1);
    chk("run_inst1", 32'(inst_o[0]), 32'h1001);
    chk("wrap_next_inst", 32'(inst_o[1]), 32'h1000);
    chk("wrap_next_pc1", 32'(pc1_o[1]), 32'h0001);
    step(0, 0, 16'h0, 0, 1);
    chk("run_inst2", 32'(inst_o[0]), 32'h1002);

    // Stall on 1002 for three cycles.
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 16'h0, 0, 1);
      chk("stall_inst", 32'(inst_o[0]), 32'h1002);
      chk("stall_pc1", 32'(pc1_o[0]), 32'h0003);
      chk("stall_pc_bound", 32'((fpc_o[0] - 16'd2) <= 16'(DEPTH)), 32'd1);
    end
    step(0, 0, 16'h0, 0, 1);
    chk("resume_inst", 32'(inst_o[0]), 32'h1003);
    chk("resume_pc1", 32'(pc1_o[0]), 32'h0004);

    // Redirect with a word in flight and the queue occupied.
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (m_req[0] && mq[0].size() >= 1) found = 1;
      else step(1'($urandom_range(0, 1)), 0, 16'h0, 0, 1);
    end
    chk("redirect_setup", 32'(found), 32'd1);
    step(0, 1, 16'h0040, 0, 1);
    chk("redir_flush0", 32'(valid_o[0]), 32'd0);
    chk("redir_flush1", 32'(valid_o[1]), 32'd0);
    chk("redir_pc", 32'(fpc_o[0]), 32'h0040);
    step(0, 0, 16'h0, 0, 1);
    step(0, 0, 16'h0, 0, 1);
    chk("redir_target_inst", 32'(inst_o[0]), 32'h1040);
    chk("redir_target_pc1", 32'(pc1_o[0]), 32'h0041);

    // Halt in steady state; remaining words drain, then fetch stays frozen.
    step(0, 0, 16'h0, 0, 1);
    step(0, 0, 16'h0, 1, 1);
    frozen_pc = fpc_o[0];
    for (int i = 0; i < 6; i++) step(0, 0, 16'h0, 0, 1);
    chk("halt_drained", 32'(valid_o[0]), 32'd0);
    chk("halt_frozen_pc", 32'(fpc_o[0]), 32'(frozen_pc));
    step(0, 1, 16'h0080, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 16'h0, 0, 1);
    chk("halt_redir_pc", 32'(fpc_o[0]), 32'h0080);
    chk("halt_redir_idle", 32'(valid_o[0]), 32'd0);

    // Async reset mid-stream.
    reset_pulse();
    for (int i = 0; i < 5; i++) step(0, 0, 16'h0, 0, 1);
    reset_pulse();
    step(0, 0, 16'h0, 0, 1);
    step(0, 0, 16'h0, 0, 1);
    chk("rst_first_inst", 32'(inst_o[0]), 32'h1000);
    chk("rst_first_valid", 32'(valid_o[1]), 32'd1);

    // Random traffic against the model, fresh RAM contents after each reset.
    for (int i = 0; i < 400; i++) begin
      if (i % 100 == 0) begin
        reset_pulse();
        for (int a = 0; a < 65536; a++) mem[a] = 16'($urandom);
      end
      step(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 16) == 0),
           16'($urandom), 1'($urandom_range(0, 60) == 0), 1'($urandom_range(0, 4) != 0));
    end
    step(0, 0, 16'h0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
